// File: rtl/hdmi_tmds_pkg.sv
// hdmi_tmds_pkg: types, code tables and decode helpers for one TMDS channel.
// Shared by the per-channel encoder and decoder.
//   - tmds_mode_e   : symbol period classification reported on the mode output
//   - align_state_e : word-alignment FSM states
//   - control tokens, TERC4 table (encode + inverse lookup), guard bands per CN
//   - video_decode  : 10b -> 8b transition-minimised decode (no disparity check)
package hdmi_tmds_pkg;

    typedef enum logic [2:0] {
        MODE_CTRL   = 3'd0,
        MODE_VIDEO  = 3'd1,
        MODE_VGUARD = 3'd2,
        MODE_ISLAND = 3'd3,
        MODE_IGUARD = 3'd4
    } tmds_mode_e;

    typedef enum logic [1:0] {
        ALIGN_SEARCH,
        ALIGN_SLIP,
        ALIGN_WAIT,
        ALIGN_LOCKED
    } align_state_e;

    // Symbols are written tmds[9:0]; bit 0 is transmitted first.
    localparam logic [9:0] CTRL_TOKEN_00    = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01    = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10    = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11    = 10'b1010101011;

    localparam logic [9:0] VIDEO_GUARD_CN02 = 10'b1011001100;
    localparam logic [9:0] VIDEO_GUARD_CN1  = 10'b0100110011;
    localparam logic [9:0] DATA_GUARD_CN12  = 10'b0100110011;

    typedef struct packed {
        logic       hit;
        logic [1:0] bits;
    } ctrl_dec_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] nib;
    } terc4_dec_t;

    // Stage-1 record: classification plus the raw symbol for stage-2 decode.
    typedef struct packed {
        tmds_mode_e mode;
        logic       is_ctrl;
        logic       ctrl_after_data;  // control token directly after a non-control symbol
        logic       ctrl_upd;
        logic [1:0] ctrl_bits;
        logic       video_upd;
        logic       nib_upd;
        logic [3:0] nib;
        logic       err;
        logic [9:0] sym;
    } stage1_t;

    function automatic ctrl_dec_t ctrl_decode(input logic [9:0] s);
        ctrl_dec_t r;
        r.hit  = 1'b1;
        r.bits = 2'b00;
        case (s)
            CTRL_TOKEN_00: r.bits = 2'b00;
            CTRL_TOKEN_01: r.bits = 2'b01;
            CTRL_TOKEN_10: r.bits = 2'b10;
            CTRL_TOKEN_11: r.bits = 2'b11;
            default:       r.hit  = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [9:0] terc4_encode(input logic [3:0] n);
        logic [9:0] s;
        case (n)
            4'h0: s = 10'b1010011100;
            4'h1: s = 10'b1001100011;
            4'h2: s = 10'b1011100100;
            4'h3: s = 10'b1011100010;
            4'h4: s = 10'b0101110001;
            4'h5: s = 10'b0100011110;
            4'h6: s = 10'b0110001110;
            4'h7: s = 10'b0100111100;
            4'h8: s = 10'b1011001100;
            4'h9: s = 10'b0100111001;
            4'hA: s = 10'b0110011100;
            4'hB: s = 10'b1011000110;
            4'hC: s = 10'b1010001110;
            4'hD: s = 10'b1001110001;
            4'hE: s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    // Inverse lookup; linear search keeps the table in one place.
    function automatic terc4_dec_t terc4_decode(input logic [9:0] s);
        terc4_dec_t r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (s == terc4_encode(4'(i))) begin
                r.legal = 1'b1;
                r.nib   = 4'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] video_decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d    = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// tmds_channel_decoder_if: symbol input and decoded output bundle of one channel.
//   tmds_in/island_hint         : toward the decoder (deserializer, packet layer)
//   video_data/data_island_data/control_data/mode/symbol_err : decoded symbol
//   bitslip/locked              : word-alignment status and SERDES request
// master = SERDES/packet-layer side, slave = decoder.
interface tmds_channel_decoder_if;
    logic [9:0] tmds_in;
    logic       island_hint;
    logic [7:0] video_data;
    logic [3:0] data_island_data;
    logic [1:0] control_data;
    logic [2:0] mode;
    logic       symbol_err;
    logic       bitslip;
    logic       locked;

    modport master (
        output tmds_in, island_hint,
        input  video_data, data_island_data, control_data, mode,
               symbol_err, bitslip, locked
    );

    modport slave (
        input  tmds_in, island_hint,
        output video_data, data_island_data, control_data, mode,
               symbol_err, bitslip, locked
    );
endinterface

// File: rtl/tmds_symbol_align.sv
// tmds_symbol_align: word-alignment FSM for one TMDS channel.
//   clk_pixel, rst_n (sync, active low)
//   is_ctrl         : stage-1 symbol is a control token
//   symbol_err      : stage-1 symbol illegal for its period
//   ctrl_after_data : control token following a non-control symbol (new line)
//   bitslip         : one-cycle slip request to the SERDES
//   locked          : alignment achieved
module tmds_symbol_align
    import hdmi_tmds_pkg::*;
#(
    parameter int CTRL_RUN     = 16,
    parameter int SEARCH_LIMIT = 1024,
    parameter int SLIP_WAIT    = 8,
    parameter int ERR_LIMIT    = 4
) (
    input  logic clk_pixel,
    input  logic rst_n,
    input  logic is_ctrl,
    input  logic symbol_err,
    input  logic ctrl_after_data,
    output logic bitslip,
    output logic locked
);
    localparam int RW = $clog2(CTRL_RUN + 1);
    localparam int SW = $clog2(SEARCH_LIMIT + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    align_state_e  state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic [SW-1:0] search_q, search_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [EW-1:0] err_q, err_d, err_inc;

    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            state_q  <= ALIGN_SEARCH;
            run_q    <= '0;
            search_q <= '0;
            wait_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            search_q <= search_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        search_d = search_q;
        wait_d   = wait_q;
        err_d    = err_q;
        err_inc  = (err_q == EW'(ERR_LIMIT)) ? err_q : err_q + 1'b1;
        case (state_q)
            ALIGN_SEARCH: begin
                run_d    = is_ctrl ? run_q + 1'b1 : '0;
                search_d = search_q + 1'b1;
                // A completed run wins over an expiring search window.
                if (is_ctrl && run_q == RW'(CTRL_RUN - 1)) begin
                    state_d = ALIGN_LOCKED;
                    err_d   = '0;
                end else if (search_q == SW'(SEARCH_LIMIT - 1)) begin
                    state_d = ALIGN_SLIP;
                end
            end
            ALIGN_SLIP: begin
                state_d = ALIGN_WAIT;
                wait_d  = '0;
            end
            ALIGN_WAIT: begin
                if (wait_q == WW'(SLIP_WAIT - 1)) begin
                    state_d  = ALIGN_SEARCH;
                    run_d    = '0;
                    search_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ALIGN_LOCKED: begin
                // Errors are counted per line; the first control token of the
                // blanking interval starts a fresh count.
                if (ctrl_after_data) begin
                    err_d = '0;
                end else if (symbol_err) begin
                    err_d = err_inc;
                    if (err_inc == EW'(ERR_LIMIT)) begin
                        state_d  = ALIGN_SEARCH;
                        run_d    = '0;
                        search_d = '0;
                        err_d    = '0;
                    end
                end
            end
            default: state_d = ALIGN_SEARCH;
        endcase
    end

    assign bitslip = (state_q == ALIGN_SLIP);
    assign locked  = (state_q == ALIGN_LOCKED);

endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: receive-side TMDS channel decoder with word alignment.
//   clk_pixel : pixel clock, one symbol per cycle
//   rst_n     : synchronous active-low reset
//   dec       : slave side of tmds_channel_decoder_if (symbol in, decoded out)
// Two-stage pipeline: stage 1 classifies the symbol, stage 2 decodes payloads.
// Payload outputs not relevant to the current mode hold their last value.
module tmds_channel_decoder
    import hdmi_tmds_pkg::*;
#(
    parameter int CN           = 0,
    parameter int CTRL_RUN     = 16,
    parameter int SEARCH_LIMIT = 1024,
    parameter int SLIP_WAIT    = 8,
    parameter int ERR_LIMIT    = 4
) (
    input  logic                    clk_pixel,
    input  logic                    rst_n,
    tmds_channel_decoder_if.slave   dec
);
    localparam logic [9:0] VGUARD = (CN == 1) ? VIDEO_GUARD_CN1 : VIDEO_GUARD_CN02;

    stage1_t    s1_d, s1_q;
    ctrl_dec_t  cd;
    terc4_dec_t td;
    tmds_mode_e prev_mode;

    tmds_mode_e mode_q;
    logic [7:0] video_q;
    logic [3:0] nib_q;
    logic [1:0] ctrl_q;
    logic       err_q;

    assign prev_mode = s1_q.mode;

    // Stage 1 classification, first match wins.
    always_comb begin
        cd        = ctrl_decode(dec.tmds_in);
        td        = terc4_decode(dec.tmds_in);
        s1_d      = '0;
        s1_d.sym  = dec.tmds_in;
        if (cd.hit) begin
            s1_d.mode            = MODE_CTRL;
            s1_d.is_ctrl         = 1'b1;
            s1_d.ctrl_after_data = (prev_mode != MODE_CTRL);
            s1_d.ctrl_upd        = 1'b1;
            s1_d.ctrl_bits       = cd.bits;
        end else if (!dec.island_hint) begin
            if (dec.tmds_in == VGUARD &&
                (prev_mode == MODE_CTRL || prev_mode == MODE_VGUARD)) begin
                s1_d.mode = MODE_VGUARD;
            end else begin
                s1_d.mode      = MODE_VIDEO;
                s1_d.video_upd = 1'b1;
            end
        end else if (CN != 0 && dec.tmds_in == DATA_GUARD_CN12) begin
            s1_d.mode = MODE_IGUARD;
        end else if (CN == 0 && td.legal && td.nib[3:2] == 2'b11 &&
                     (prev_mode == MODE_CTRL || prev_mode == MODE_IGUARD)) begin
            // Channel 0 guard carries HSYNC/VSYNC in the low nibble bits.
            // The trailing guard follows island data and lands in the next
            // branch as an ordinary 11xx nibble.
            s1_d.mode      = MODE_IGUARD;
            s1_d.ctrl_upd  = 1'b1;
            s1_d.ctrl_bits = td.nib[1:0];
        end else begin
            s1_d.mode    = MODE_ISLAND;
            s1_d.nib_upd = 1'b1;
            s1_d.nib     = td.legal ? td.nib : 4'h0;
            s1_d.err     = ~td.legal;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    // Stage 2: payload decode and output registers.
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            mode_q  <= MODE_CTRL;
            video_q <= '0;
            nib_q   <= '0;
            ctrl_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            mode_q <= s1_q.mode;
            err_q  <= s1_q.err;
            if (s1_q.ctrl_upd)  ctrl_q  <= s1_q.ctrl_bits;
            if (s1_q.video_upd) video_q <= video_decode(s1_q.sym);
            if (s1_q.nib_upd)   nib_q   <= s1_q.nib;
        end
    end

    tmds_symbol_align #(
        .CTRL_RUN     (CTRL_RUN),
        .SEARCH_LIMIT (SEARCH_LIMIT),
        .SLIP_WAIT    (SLIP_WAIT),
        .ERR_LIMIT    (ERR_LIMIT)
    ) u_align (
        .clk_pixel       (clk_pixel),
        .rst_n           (rst_n),
        .is_ctrl         (s1_q.is_ctrl),
        .symbol_err      (s1_q.err),
        .ctrl_after_data (s1_q.ctrl_after_data),
        .bitslip         (dec.bitslip),
        .locked          (dec.locked)
    );

    assign dec.mode             = mode_q;
    assign dec.video_data       = video_q;
    assign dec.data_island_data = nib_q;
    assign dec.control_data     = ctrl_q;
    assign dec.symbol_err       = err_q;

endmodule
